icache_victim_sel: RTL and testbench
====================================

// Module: icache_victim_sel
// PURPOSE
//  Victim-way selector and replacement controller for the set-associative icache.
//  - On a miss, picks the way to refill: an invalid way first, otherwise the way
//    marked by the round-robin one-hot pointer.
//  - Holds the choice stable for the whole refill.
//  - After the refill commits, pulses the pointer's advance input, so the pointer
//    moves once per replacement it actually caused.
// PARAMETERS
//  N_WAYS     default 2                   number of ways; equals the pointer length, >= 2
//  WAY_IDX_W  default $clog2(N_WAYS)      binary way index width (derived, do not override)
// PORTS
//  clk_i           in   1          clock; all state updates on the rising edge
//  rst_i           in   1          asynchronous, active-high reset
//  miss_valid_i    in   1          miss request from icache control
//  miss_ready_o    out  1          selector idle and able to accept a miss
//  way_valid_i     in   N_WAYS     valid bits of the missed set, sampled on accept
//  rr_ptr_i        in   N_WAYS     one-hot round-robin pointer, sampled on accept
//  victim_valid_o  out  1          victim outputs are valid and stable
//  victim_way_o    out  N_WAYS     one-hot victim way
//  victim_idx_o    out  WAY_IDX_W  binary victim way index
//  refill_done_i   in   1          refill of the victim line is complete
//  refill_abort_i  in   1          flush/abort of the pending refill
//  rr_update_o     out  1          one-cycle pulse that advances the round-robin pointer
//  err_o           out  1          sticky flag: a non-one-hot rr_ptr_i was sampled
// BEHAVIOUR
//  Reset: state=IDLE, miss_ready_o=1, victim_valid_o=0, victim_way_o=0,
//    victim_idx_o=0, rr_update_o=0, err_o=0.
//  Reset mid-operation: asynchronous return to the same values; no rr_update_o pulse.
//  FSM states: IDLE, BUSY, COMMIT.
//  - IDLE: miss_ready_o=1. A miss is accepted when miss_valid_i=1 on a clock edge.
//    On that edge the victim is computed and registered, and the FSM goes to BUSY.
//    Latency: victim_valid_o=1 in the first cycle after accept.
//  - BUSY: victim_valid_o=1; victim_way_o and victim_idx_o are held constant;
//    miss_ready_o=0.
//    - refill_abort_i=1: go to IDLE, with no pointer update.
//    - refill_done_i=1 with no abort: go to COMMIT.
//    - Both asserted in the same cycle: abort wins.
//  - COMMIT: lasts exactly one cycle; victim_valid_o=0; miss_ready_o=0.
//    - rr_update_o=1 only if the victim came from the pointer (from_rr flag).
//    - The FSM then returns to IDLE.
//  Victim rule: the lowest-index way with way_valid_i=0 (invalid-first); if every way
//    is valid, the victim is rr_ptr_i.
//  Pointer check: if rr_ptr_i does not have exactly one bit set at accept:
//    - victim = way N_WAYS-1 (the pointer's reset position);
//    - from_rr=1;
//    - err_o is set and stays set until reset.
//  victim_idx_o is always the binary encoding of victim_way_o.
//  rr_update_o never pulses more than once per accepted miss; it never pulses outside COMMIT.
// CONFIGURATION
//  Macro ICACHE_VICTIM_INVALID_FIRST_EN:
//  - Defined: the invalid-first rule above applies.
//  - Undefined: way_valid_i is ignored; the victim is always the pointer (or the
//    error fallback), from_rr is always 1, and every COMMIT pulses rr_update_o.
// STRUCTURE
//  memory_pkg:
//  - constant ICACHE_N_WAYS, used as the top-level value of N_WAYS;
//  - typedef enum logic [1:0] {VS_IDLE, VS_BUSY, VS_COMMIT} victim_sel_state_t.
//  Sub-module icache_way_prio_enc:
//  - combinational; lowest-set-bit priority encoder;
//  - outputs a one-hot vector, a binary index and a "none" flag;
//  - instantiated once on ~way_valid_i and once for one-hot-to-index conversion.
//  The FSM, victim registers, from_rr flag and error flag live in this module.
// TESTING (N_WAYS=4, macro defined unless stated)
//  1. Assert reset -> miss_ready_o=1, victim_valid_o=0, rr_update_o=0, err_o=0.
//  2. way_valid=1111, rr_ptr=0100, miss accepted -> next cycle victim_way=0100, idx=2.
//     refill_done -> one COMMIT cycle with rr_update_o=1, then miss_ready_o=1.
//  3. way_valid=1011, rr_ptr=0001, miss -> victim_way=0100, idx=2.
//     After refill_done, rr_update_o stays 0 in COMMIT.
//  4. In BUSY, refill_abort_i=1 together with refill_done_i=1 -> IDLE next cycle,
//     rr_update_o never 1.
//     Async reset while in BUSY -> outputs return to reset values immediately.
//  5. rr_ptr=0110, way_valid=1111 -> victim_way=1000, idx=3, err_o=1.
//     err_o stays 1 across later good misses, until reset.
//  6. Macro undefined, stimulus as in scenario 3 -> victim_way=0001, idx=0,
//     rr_update_o=1 in COMMIT.

Source files
------------

// File: rtl/memory_pkg.sv
// Shared icache memory-side types: way count and the victim selector state encoding.
package memory_pkg;

    localparam int ICACHE_N_WAYS = 2;

    typedef enum logic [1:0] {
        VS_IDLE   = 2'd0,
        VS_BUSY   = 2'd1,
        VS_COMMIT = 2'd2
    } victim_sel_state_t;

endpackage

// File: rtl/icache_way_prio_enc.sv
// Lowest-set-bit priority encoder: one-hot winner, binary index and an empty flag.
// Purely combinational, zero latency, no flow control.
module icache_way_prio_enc #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             none
);

    // Scan from the top down so the lowest set bit is the last (winning) assignment.
    always_comb begin
        onehot = '0;
        idx    = '0;
        none   = 1'b1;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = IDX_W'(i);
                none      = 1'b0;
            end
        end
    end

endmodule

// File: rtl/icache_victim_sel.sv
// Victim-way selector for icache refills; victim valid one cycle after accept, held until done/abort.
// Accepts a new miss only in IDLE. ICACHE_VICTIM_INVALID_FIRST_EN enables invalid-way-first selection.
module icache_victim_sel
    import memory_pkg::*;
#(
    parameter int N_WAYS    = ICACHE_N_WAYS,
    parameter int WAY_IDX_W = $clog2(N_WAYS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 miss_valid_i,
    output logic                 miss_ready_o,
    input  logic [N_WAYS-1:0]    way_valid_i,
    input  logic [N_WAYS-1:0]    rr_ptr_i,
    output logic                 victim_valid_o,
    output logic [N_WAYS-1:0]    victim_way_o,
    output logic [WAY_IDX_W-1:0] victim_idx_o,
    input  logic                 refill_done_i,
    input  logic                 refill_abort_i,
    output logic                 rr_update_o,
    output logic                 err_o
);

    victim_sel_state_t state_q, state_d;

    logic [N_WAYS-1:0]    victim_way_q;
    logic [WAY_IDX_W-1:0] victim_idx_q;
    logic                 from_rr_q;
    logic                 err_q;

    logic                 accept;
    logic                 ptr_ok;
    logic [N_WAYS-1:0]    ptr_way;
    logic [N_WAYS-1:0]    victim_d;
    logic [WAY_IDX_W-1:0] victim_idx_d;
    logic                 from_rr_d;

    // A malformed pointer falls back to the top way, where the pointer sits out of reset.
    assign ptr_ok  = (rr_ptr_i != '0) && ((rr_ptr_i & (rr_ptr_i - N_WAYS'(1))) == '0);
    assign ptr_way = ptr_ok ? rr_ptr_i : {1'b1, {(N_WAYS-1){1'b0}}};

`ifdef ICACHE_VICTIM_INVALID_FIRST_EN
    logic [N_WAYS-1:0]    inv_way;
    logic [WAY_IDX_W-1:0] inv_idx_unused;
    logic                 inv_none;

    icache_way_prio_enc #(
        .N     (N_WAYS),
        .IDX_W (WAY_IDX_W)
    ) u_inv_enc (
        .req    (~way_valid_i),
        .onehot (inv_way),
        .idx    (inv_idx_unused),
        .none   (inv_none)
    );

    assign victim_d  = inv_none ? ptr_way : inv_way;
    assign from_rr_d = inv_none;
`else
    logic unused_way_valid;
    assign unused_way_valid = ^way_valid_i;

    assign victim_d  = ptr_way;
    assign from_rr_d = 1'b1;
`endif

    logic [N_WAYS-1:0] victim_oh_unused;
    logic              victim_none_unused;

    icache_way_prio_enc #(
        .N     (N_WAYS),
        .IDX_W (WAY_IDX_W)
    ) u_idx_enc (
        .req    (victim_d),
        .onehot (victim_oh_unused),
        .idx    (victim_idx_d),
        .none   (victim_none_unused)
    );

    always_comb begin
        state_d        = state_q;
        accept         = 1'b0;
        miss_ready_o   = 1'b0;
        victim_valid_o = 1'b0;
        rr_update_o    = 1'b0;
        case (state_q)
            VS_IDLE: begin
                miss_ready_o = 1'b1;
                if (miss_valid_i) begin
                    accept  = 1'b1;
                    state_d = VS_BUSY;
                end
            end
            VS_BUSY: begin
                victim_valid_o = 1'b1;
                // Abort takes priority over a simultaneous done.
                if (refill_abort_i) begin
                    state_d = VS_IDLE;
                end else if (refill_done_i) begin
                    state_d = VS_COMMIT;
                end
            end
            VS_COMMIT: begin
                rr_update_o = from_rr_q;
                state_d     = VS_IDLE;
            end
            default: begin
                state_d = VS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= VS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            victim_way_q <= '0;
            victim_idx_q <= '0;
            from_rr_q    <= 1'b0;
            err_q        <= 1'b0;
        end else if (accept) begin
            victim_way_q <= victim_d;
            victim_idx_q <= victim_idx_d;
            from_rr_q    <= from_rr_d;
            if (!ptr_ok) begin
                err_q <= 1'b1;
            end
        end
    end

    assign victim_way_o = victim_way_q;
    assign victim_idx_o = victim_idx_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_icache_victim_sel.sv
// Bench for icache_victim_sel with four ways: directed vector table, hand sequences and random misses.
module tb_icache_victim_sel;

    localparam int NW = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          miss_valid_i;
    logic          miss_ready_o;
    logic [NW-1:0] way_valid_i;
    logic [NW-1:0] rr_ptr_i;
    logic          victim_valid_o;
    logic [NW-1:0] victim_way_o;
    logic [1:0]    victim_idx_o;
    logic          refill_done_i;
    logic          refill_abort_i;
    logic          rr_update_o;
    logic          err_o;

    icache_victim_sel #(.N_WAYS(NW)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .miss_valid_i   (miss_valid_i),
        .miss_ready_o   (miss_ready_o),
        .way_valid_i    (way_valid_i),
        .rr_ptr_i       (rr_ptr_i),
        .victim_valid_o (victim_valid_o),
        .victim_way_o   (victim_way_o),
        .victim_idx_o   (victim_idx_o),
        .refill_done_i  (refill_done_i),
        .refill_abort_i (refill_abort_i),
        .rr_update_o    (rr_update_o),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [NW-1:0] vv;
        logic [NW-1:0] ptr;
        logic [NW-1:0] way;
        int            idx;
        bit            upd;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Reference: the victim is derived straight from the selection rules.
    task automatic model(input logic [NW-1:0] vv, input logic [NW-1:0] ptr,
                         output logic [NW-1:0] way, output int idx,
                         output bit from_rr, output bit bad);
        int ones;
        ones = 0;
        for (int i = 0; i < NW; i++) if (ptr[i]) ones++;
        bad = (ones != 1);
        idx = -1;
`ifdef ICACHE_VICTIM_INVALID_FIRST_EN
        for (int i = 0; i < NW; i++) if (!vv[i] && idx < 0) idx = i;
`endif
        from_rr = (idx < 0);
        if (from_rr) begin
            if (bad) idx = NW - 1;
            else for (int i = 0; i < NW; i++) if (ptr[i]) idx = i;
        end
        way = '0;
        way[idx] = 1'b1;
    endtask

    // mode: 0 = done, 1 = abort only, 2 = abort and done together
    task automatic run_miss(input logic [NW-1:0] vv, input logic [NW-1:0] ptr,
                            input int hold, input int mode,
                            input logic [NW-1:0] exp_way, input int exp_idx,
                            input bit exp_upd, input bit exp_err, input string tag);
        check({tag, ".idle_ready"}, int'(miss_ready_o), 1);
        miss_valid_i = 1'b1;
        way_valid_i  = vv;
        rr_ptr_i     = ptr;
        step();
        miss_valid_i = 1'b0;
        way_valid_i  = NW'($urandom);
        rr_ptr_i     = NW'($urandom);
        check({tag, ".valid"}, int'(victim_valid_o), 1);
        check({tag, ".busy_ready"}, int'(miss_ready_o), 0);
        check({tag, ".way"}, int'(victim_way_o), int'(exp_way));
        check({tag, ".idx"}, int'(victim_idx_o), exp_idx);
        check({tag, ".err"}, int'(err_o), int'(exp_err));
        for (int h = 0; h < hold; h++) begin
            step();
            way_valid_i = NW'($urandom);
            rr_ptr_i    = NW'($urandom);
            check({tag, ".hold_way"}, int'(victim_way_o), int'(exp_way));
            check({tag, ".hold_valid"}, int'(victim_valid_o), 1);
            check({tag, ".hold_upd"}, int'(rr_update_o), 0);
        end
        refill_done_i  = (mode != 1);
        refill_abort_i = (mode != 0);
        step();
        refill_done_i  = 1'b0;
        refill_abort_i = 1'b0;
        if (mode == 0) begin
            check({tag, ".commit_valid"}, int'(victim_valid_o), 0);
            check({tag, ".commit_ready"}, int'(miss_ready_o), 0);
            check({tag, ".commit_upd"}, int'(rr_update_o), int'(exp_upd));
            step();
        end
        check({tag, ".after_ready"}, int'(miss_ready_o), 1);
        check({tag, ".after_valid"}, int'(victim_valid_o), 0);
        check({tag, ".after_upd"}, int'(rr_update_o), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".ready"}, int'(miss_ready_o), 1);
        check({tag, ".valid"}, int'(victim_valid_o), 0);
        check({tag, ".way"}, int'(victim_way_o), 0);
        check({tag, ".idx"}, int'(victim_idx_o), 0);
        check({tag, ".upd"}, int'(rr_update_o), 0);
        check({tag, ".err"}, int'(err_o), 0);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        #3;
        check_reset_vals("reset");
        @(negedge clk_i);
        rst_i = 1'b0;
        step();
    endtask

    initial begin
        logic [NW-1:0] m_way;
        int            m_idx;
        bit            m_rr;
        bit            m_bad;
        bit            err_exp;
        int            mode;
        logic [NW-1:0] vv;
        logic [NW-1:0] ptr;

        tbl[0] = '{vv: 4'b1111, ptr: 4'b0100, way: 4'b0100, idx: 2, upd: 1'b1};
`ifdef ICACHE_VICTIM_INVALID_FIRST_EN
        tbl[1] = '{vv: 4'b1011, ptr: 4'b0001, way: 4'b0100, idx: 2, upd: 1'b0};
        tbl[2] = '{vv: 4'b0000, ptr: 4'b1000, way: 4'b0001, idx: 0, upd: 1'b0};
        tbl[3] = '{vv: 4'b1110, ptr: 4'b0010, way: 4'b0001, idx: 0, upd: 1'b0};
        tbl[4] = '{vv: 4'b0111, ptr: 4'b0001, way: 4'b1000, idx: 3, upd: 1'b0};
`else
        tbl[1] = '{vv: 4'b1011, ptr: 4'b0001, way: 4'b0001, idx: 0, upd: 1'b1};
        tbl[2] = '{vv: 4'b0000, ptr: 4'b1000, way: 4'b1000, idx: 3, upd: 1'b1};
        tbl[3] = '{vv: 4'b1110, ptr: 4'b0010, way: 4'b0010, idx: 1, upd: 1'b1};
        tbl[4] = '{vv: 4'b0111, ptr: 4'b0001, way: 4'b0001, idx: 0, upd: 1'b1};
`endif

        miss_valid_i   = 1'b0;
        way_valid_i    = '0;
        rr_ptr_i       = '0;
        refill_done_i  = 1'b0;
        refill_abort_i = 1'b0;
        do_reset();
        check_reset_vals("post_reset");

        foreach (tbl[i])
            run_miss(tbl[i].vv, tbl[i].ptr, i % 3, 0, tbl[i].way, tbl[i].idx, tbl[i].upd, 1'b0,
                     $sformatf("vec%0d", i));

        // Abort alone and abort together with done: no pointer advance.
        run_miss(4'b1111, 4'b0010, 1, 1, 4'b0010, 1, 1'b0, 1'b0, "abort");
        run_miss(4'b1111, 4'b0100, 0, 2, 4'b0100, 2, 1'b0, 1'b0, "abort_done");

        // Asynchronous reset in the middle of a refill.
        miss_valid_i = 1'b1;
        way_valid_i  = 4'b1111;
        rr_ptr_i     = 4'b1000;
        step();
        miss_valid_i = 1'b0;
        check("areset.busy_valid", int'(victim_valid_o), 1);
        #2;
        rst_i = 1'b1;
        #1;
        check_reset_vals("areset");
        refill_done_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        step();
        refill_done_i = 1'b0;
        check("areset.no_upd", int'(rr_update_o), 0);
        check("areset.idle", int'(miss_ready_o), 1);

        // Malformed pointer: fallback to top way, sticky error.
        run_miss(4'b1111, 4'b0110, 0, 0, 4'b1000, 3, 1'b1, 1'b1, "badptr");
        run_miss(4'b1111, 4'b0001, 0, 0, 4'b0001, 0, 1'b1, 1'b1, "err_sticky1");
        run_miss(4'b1111, 4'b0010, 1, 1, 4'b0010, 1, 1'b0, 1'b1, "err_sticky2");
        do_reset();

        err_exp = 1'b0;
        for (int n = 0; n < 150; n++) begin
            vv = NW'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) ptr = NW'($urandom_range(0, 15));
            else ptr = NW'(1 << $urandom_range(0, NW - 1));
            model(vv, ptr, m_way, m_idx, m_rr, m_bad);
            err_exp = err_exp | m_bad;
            mode = $urandom_range(0, 3);
            if (mode == 3) mode = 0;
            run_miss(vv, ptr, $urandom_range(0, 3), mode, m_way, m_idx, m_rr, err_exp,
                     $sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
